// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: front-end controller for the shared multi-cycle FP add/mul
// datapath. Accepts one operation at a time and classifies both operands.
// NaN/inf/zero cases are resolved locally. Finite non-zero pairs, including
// subnormals, go to the datapath over a start/done handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; in_op (0=add, 1=mul), in_a, in_b
//   dp_start            one-cycle datapath launch pulse
//   dp_op/dp_a/dp_b     registered operation and operands to the datapath
//   dp_done/dp_result   datapath completion pulse and its result
//   out_valid/out_ready result handshake; out_result, out_invalid, out_special
//   busy                high in every state except IDLE
module fpu_op_sequencer #(
  parameter int unsigned num_bits   = 16,
  parameter int unsigned exp_width  = 5,
  parameter int unsigned mant_width = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_op,
  input  logic [num_bits-1:0] in_a,
  input  logic [num_bits-1:0] in_b,
  output logic                dp_start,
  output logic                dp_op,
  output logic [num_bits-1:0] dp_a,
  output logic [num_bits-1:0] dp_b,
  input  logic                dp_done,
  input  logic [num_bits-1:0] dp_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [num_bits-1:0] out_result,
  output logic                out_invalid,
  output logic                out_special,
  output logic                busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLASS = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam int unsigned exp_msb = num_bits - 2;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  localparam logic [num_bits-1:0] qnan_c =
    {1'b0, {exp_width{1'b1}}, 1'b1, {(mant_width-1){1'b0}}};

  logic [2:0]          state, state_nxt;
  logic                in_ready_nxt, dp_start_nxt, out_valid_nxt, busy_nxt;
  logic                dp_op_nxt;
  logic [num_bits-1:0] dp_a_nxt, dp_b_nxt, out_result_nxt;
  logic                out_invalid_nxt, out_special_nxt;

  // Operand field split of the registered operands.
  logic                  sa, sb;
  logic [exp_width-1:0]  ea, eb;
  logic [mant_width-1:0] ma, mb;

  assign sa = dp_a[num_bits-1];
  assign sb = dp_b[num_bits-1];
  assign ea = dp_a[exp_msb -: exp_width];
  assign eb = dp_b[exp_msb -: exp_width];
  assign ma = dp_a[mant_width-1:0];
  assign mb = dp_b[mant_width-1:0];

  // Operand classes. Subnormal and normal are both "finite non-zero" here.
  logic a_zero, a_inf, a_qnan, a_snan;
  logic b_zero, b_inf, b_qnan, b_snan;

  assign a_zero = (~|ea) & (~|ma);
  assign a_inf  = (&ea) & (~|ma);
  assign a_qnan = (&ea) & ma[mant_width-1];
  assign a_snan = (&ea) & (|ma) & ~ma[mant_width-1];
  assign b_zero = (~|eb) & (~|mb);
  assign b_inf  = (&eb) & (~|mb);
  assign b_qnan = (&eb) & mb[mant_width-1];
  assign b_snan = (&eb) & (|mb) & ~mb[mant_width-1];

  // Special-case resolution; the first matching rule wins.
  logic                spec_hit;
  logic [num_bits-1:0] spec_res;
  logic                spec_inv;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_inv = 1'b0;
    if (a_snan || b_snan) begin
      spec_res = qnan_c;
      spec_inv = 1'b1;
    end else if (a_qnan || b_qnan) begin
      spec_res = qnan_c;
    end else if (dp_op) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        spec_res = qnan_c;
        spec_inv = 1'b1;
      end else if (a_inf || b_inf) begin
        spec_res = {sa ^ sb, {exp_width{1'b1}}, {mant_width{1'b0}}};
      end else if (a_zero || b_zero) begin
        spec_res = {sa ^ sb, {(num_bits-1){1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if (a_inf && b_inf && (sa != sb)) begin
        spec_res = qnan_c;
        spec_inv = 1'b1;
      end else if (a_inf) begin
        spec_res = dp_a;
      end else if (b_inf) begin
        spec_res = dp_b;
      end else if (a_zero && b_zero) begin
        spec_res = {sa & sb, {(num_bits-1){1'b0}}};
      end else if (a_zero) begin
        spec_res = dp_b;
      end else if (b_zero) begin
        spec_res = dp_a;
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // Next-state and next-output logic; every output is a register.
  always_comb begin
    state_nxt       = state;
    dp_op_nxt       = dp_op;
    dp_a_nxt        = dp_a;
    dp_b_nxt        = dp_b;
    out_result_nxt  = out_result;
    out_invalid_nxt = out_invalid;
    out_special_nxt = out_special;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          dp_op_nxt = in_op;
          dp_a_nxt  = in_a;
          dp_b_nxt  = in_b;
          state_nxt = CLASS;
        end
      end
      CLASS: begin
        if (spec_hit) begin
          out_result_nxt  = spec_res;
          out_invalid_nxt = spec_inv;
          out_special_nxt = 1'b1;
          state_nxt       = RESP;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          out_result_nxt  = dp_result;
          out_invalid_nxt = 1'b0;
          out_special_nxt = 1'b0;
          state_nxt       = RESP;
        end
      end
      RESP: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Handshake/status outputs are decoded from the next state so they are
    // registered yet line up with the state they describe.
    in_ready_nxt  = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    dp_start_nxt  = (state_nxt == ISSUE);
    out_valid_nxt = (state_nxt == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      dp_start    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      dp_op       <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
      out_result  <= '0;
      out_invalid <= 1'b0;
      out_special <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready    <= in_ready_nxt;
      dp_start    <= dp_start_nxt;
      out_valid   <= out_valid_nxt;
      busy        <= busy_nxt;
      dp_op       <= dp_op_nxt;
      dp_a        <= dp_a_nxt;
      dp_b        <= dp_b_nxt;
      out_result  <= out_result_nxt;
      out_invalid <= out_invalid_nxt;
      out_special <= out_special_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [15:0] in_a, in_b;
  logic        dp_start, dp_op;
  logic [15:0] dp_a, dp_b;
  logic        dp_done;
  logic [15:0] dp_result;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_invalid, out_special, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.num_bits(16), .exp_width(5), .mant_width(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .dp_start(dp_start), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_invalid(out_invalid), .out_special(out_special), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on a falling edge; returns on the falling edge after
  // the accepting rising edge (design is then in CLASS).
  task automatic send(input string tag, input logic op, input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge clk);
    chk({tag, ".in_ready"}, 16'(in_ready), 16'h1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".busy"}, 16'(busy), 16'h1);
  endtask

  // Consume the result with a one-cycle out_ready and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 16'(out_valid), 16'h0);
    chk({tag, ".idle"}, {14'h0, busy, in_ready}, 16'h1);
  endtask

  task automatic special(input string tag, input logic op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic inv);
    send(tag, op, a, b);
    chk({tag, ".cls"}, {14'h0, dp_start, out_valid}, 16'h0);
    @(negedge clk);
    chk({tag, ".ov"}, 16'(out_valid), 16'h1);
    chk({tag, ".nostart"}, 16'(dp_start), 16'h0);
    chk({tag, ".res"}, out_result, res);
    chk({tag, ".flags"}, {14'h0, out_invalid, out_special}, {14'h0, inv, 1'b1});
    drain(tag);
  endtask

  task automatic dprun(input string tag, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input int lat, input logic [15:0] res);
    send(tag, op, a, b);
    chk({tag, ".cls"}, 16'(dp_start), 16'h0);
    @(negedge clk);
    chk({tag, ".start"}, 16'(dp_start), 16'h1);
    chk({tag, ".dp_a"}, dp_a, a);
    chk({tag, ".dp_b"}, dp_b, b);
    chk({tag, ".dp_op"}, 16'(dp_op), 16'(op));
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({tag, ".wait"}, {14'h0, dp_start, out_valid}, 16'h0);
    end
    @(negedge clk);
    dp_done   = 1'b1;
    dp_result = res;
    @(negedge clk);
    dp_done   = 1'b0;
    dp_result = 16'h0;
    chk({tag, ".ov"}, 16'(out_valid), 16'h1);
    chk({tag, ".res"}, out_result, res);
    chk({tag, ".flags"}, {14'h0, out_invalid, out_special}, 16'h0);
    drain(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
    dp_done = 1'b0; dp_result = '0; out_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst.hs", {12'h0, in_ready, dp_start, out_valid, busy}, 16'h8);
    chk("rst.res", out_result, 16'h0);
    chk("rst.dp", dp_a | dp_b, 16'h0);
    chk("rst.flags", {13'h0, out_invalid, out_special, dp_op}, 16'h0);
    rst_n = 1'b1;

    // Datapath path: 1.0 * 2.0, done three cycles after launch.
    dprun("mul_dp", 1'b1, 16'h3C00, 16'h4000, 3, 16'h4000);
    // Subnormal operands are not special.
    dprun("add_sub", 1'b0, 16'h0001, 16'h0001, 1, 16'h0002);

    // Special cases.
    special("mul_infz", 1'b1, 16'h7C00, 16'h8000, 16'h7E00, 1'b1);
    special("add_infm", 1'b0, 16'h7C00, 16'hFC00, 16'h7E00, 1'b1);
    special("add_snan", 1'b0, 16'h7D00, 16'h3C00, 16'h7E00, 1'b1);
    special("add_qnan", 1'b0, 16'h7E01, 16'h3C00, 16'h7E00, 1'b0);
    special("mul_qs",   1'b1, 16'h7E00, 16'h7D00, 16'h7E00, 1'b1);
    special("add_nz",   1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b0);
    special("mul_zero", 1'b1, 16'h8000, 16'h3C00, 16'h8000, 1'b0);
    special("mul_inf",  1'b1, 16'h7C00, 16'hC000, 16'hFC00, 1'b0);
    special("add_inf",  1'b0, 16'h3C00, 16'hFC00, 16'hFC00, 1'b0);
    special("add_pz",   1'b0, 16'h0000, 16'h8000, 16'h0000, 1'b0);

    // Back-pressure: result held while in_valid waits for the next IDLE.
    send("stall", 1'b0, 16'h0000, 16'hBC00);
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 16'h7C00; in_b = 16'h3C00;
    for (int i = 0; i < 5; i++) begin
      chk("stall.ov", 16'(out_valid), 16'h1);
      chk("stall.res", out_result, 16'hBC00);
      chk("stall.inrdy", 16'(in_ready), 16'h0);
      @(negedge clk);
    end
    chk("stall.held", {15'h0, out_valid}, 16'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall.idle", {14'h0, in_ready, out_valid}, 16'h2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall.acc", {14'h0, busy, in_ready}, 16'h2);
    @(negedge clk);
    chk("stall.ov2", 16'(out_valid), 16'h1);
    chk("stall.res2", out_result, 16'h7C00);
    chk("stall.fl2", {14'h0, out_invalid, out_special}, 16'h1);
    drain("stall");

    // Reset during WAIT, then a stray dp_done.
    send("rstw", 1'b0, 16'h3C00, 16'h3C00);
    repeat (2) @(negedge clk);
    chk("rstw.wait", {14'h0, busy, dp_start}, 16'h2);
    rst_n = 1'b0;
    #1;
    chk("rstw.async", {12'h0, in_ready, dp_start, out_valid, busy}, 16'h8);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dp_done = 1'b1; dp_result = 16'h1234;
    @(negedge clk);
    dp_done = 1'b0; dp_result = 16'h0;
    chk("rstw.hs", {12'h0, in_ready, dp_start, out_valid, busy}, 16'h8);
    chk("rstw.res", out_result, 16'h0);
    chk("rstw.dp", dp_a | dp_b, 16'h0);
    @(negedge clk);
    chk("rstw.stray", {15'h0, out_valid}, 16'h0);
    dprun("after_rst", 1'b1, 16'h3C00, 16'h3C00, 2, 16'h3C00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
